parallel_to_serial: RTL

Serializer that converts handshaked parallel words into a one-bit-per-cycle stream of `serial_valid`/`serial_data` pulses. It is the transmit-side counterpart of `serial_to_parallel`: it drives a link whose far end reassembles words from that same serial protocol. Its one-word holding buffer lets back-to-back words go out with no idle cycle between them.

---
 rtl/parallel_to_serial.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/parallel_to_serial.sv
// ---------------------------------------------------------------------------
// parallel_to_serial
//   Serializer: takes handshaked parallel words and emits them one bit per
//   clock on serial_valid/serial_data. A one-word holding register lets the
//   next word queue up while the current one is shifting, so a continuous
//   upstream produces a gap-free bit stream.
//
// Parameters
//   width      word width in bits (>= 2)
//   msb_first  0: bit 0 goes out first; 1: bit width-1 goes out first
//
// Ports
//   clk             clock, rising edge
//   rst             synchronous active-high reset
//   parallel_valid  upstream word valid
//   parallel_data   upstream word, sampled only on accept
//   parallel_ready  block can take a word this cycle (= holding reg empty)
//   serial_valid    serial_data carries a bit this cycle
//   serial_data     serial bit, forced to 0 when serial_valid is 0
//   busy            word in flight or holding register occupied
// ---------------------------------------------------------------------------
module parallel_to_serial #(
  parameter int width     = 8,
  parameter bit msb_first = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             parallel_valid,
  input  logic [width-1:0] parallel_data,
  output logic             parallel_ready,
  output logic             serial_valid,
  output logic             serial_data,
  output logic             busy
);

  localparam int cnt_w = $clog2(width);
  // Explicit terminal count: width need not be a power of two, so the
  // counter cannot be left to wrap on its own.
  localparam logic [cnt_w-1:0] last_count = cnt_w'(width - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [width-1:0] shift_reg, shift_next;
  logic [width-1:0] hold_reg, hold_next;
  logic             hold_full_reg, hold_full_next;
  logic [cnt_w-1:0] count_reg, count_next;
  logic [width-1:0] shifted;
  logic             accept;
  logic             last_bit;

  assign accept   = parallel_valid && parallel_ready;
  assign last_bit = (count_reg == last_count);

  // Shift register advanced by one position toward the output end; the
  // vacated bit is filled with 0.
  for (genvar gi = 0; gi < width; gi++) begin : g_shift
    if (msb_first) begin : g_msb
      if (gi == 0) begin : g_fill
        assign shifted[gi] = 1'b0;
      end else begin : g_move
        assign shifted[gi] = shift_reg[gi-1];
      end
    end else begin : g_lsb
      if (gi == width - 1) begin : g_fill
        assign shifted[gi] = 1'b0;
      end else begin : g_move
        assign shifted[gi] = shift_reg[gi+1];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      count_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      count_reg     <= count_next;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    count_next     = count_reg;

    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          shift_next = parallel_data;
          count_next = '0;
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        if (!last_bit) begin
          shift_next = shifted;
          count_next = count_reg + cnt_w'(1);
          if (accept) begin
            hold_next      = parallel_data;
            hold_full_next = 1'b1;
          end
        end else if (hold_full_reg) begin
          // parallel_ready is low here, so no word can arrive this cycle.
          shift_next     = hold_reg;
          hold_full_next = 1'b0;
          count_next     = '0;
        end else if (accept) begin
          // Bypass: the word goes straight into the shifter, keeping the
          // stream gap-free without touching the holding register.
          shift_next = parallel_data;
          count_next = '0;
        end else begin
          shift_next = shifted;
          count_next = '0;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Outputs, all decoded from registered state
  always_comb begin
    parallel_ready = !hold_full_reg;
    serial_valid   = (state_reg == SHIFT);
    busy           = (state_reg == SHIFT) || hold_full_reg;
    serial_data    = 1'b0;
    if (state_reg == SHIFT) begin
      serial_data = msb_first ? shift_reg[width-1] : shift_reg[0];
    end
  end

endmodule
